// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acc_pkg
//  Description : Shared definitions for the ICB accelerator front-end:
//                register offsets inside the 4 KB window, the load-target
//                mode encoding and the front-end FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package acc_pkg;

   // Byte offsets inside the accelerator window
   localparam logic [11:0] CTRL_OFS    = 12'h000;
   localparam logic [11:0] MODE_OFS    = 12'h004;
   localparam logic [11:0] DATA_OFS_LO = 12'h008;
   localparam logic [11:0] DATA_OFS_HI = 12'hFFF;

   // Load-target select driven to the core
   typedef enum logic [1:0] {
      MODE_RUN   = 2'd0,
      MODE_IFMAP = 2'd1,
      MODE_LUT   = 2'd2,
      MODE_RSVD  = 2'd3
   } mode_e;

   // Front-end transaction FSM
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RD_WAIT = 2'd1,
      S_RSP     = 2'd2
   } state_e;

endpackage
`default_nettype wire

// File: rtl/icb_addr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : icb_addr_decode
//  Description : Combinational decode of an ICB byte address into the
//                accelerator register map.
//  Ports       : addr    - ICB command address
//                is_ctrl - CTRL register hit
//                is_mode - MODE register hit
//                is_data - DATA window hit
//                buf_idx - buffer word index (raw offset minus DATA base)
//                err     - address not mapped (includes out-of-window)
//  Revision    : 1.0  initial release
// ============================================================================
module icb_addr_decode
   import acc_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h1004_2000,
   parameter int          BUF_AW    = 12
) (
   input  logic [31:0]       addr,
   output logic              is_ctrl,
   output logic              is_mode,
   output logic              is_data,
   output logic [BUF_AW-1:0] buf_idx,
   output logic              err
);

   logic [31:0] offset;
   logic [11:0] ofs12;
   logic        in_win;
   logic [11:0] idx_full;

   // Addresses below the base wrap to a huge offset and fall outside the window
   assign offset   = addr - BASE_ADDR;
   assign in_win   = (offset[31:12] == 20'd0);
   assign ofs12    = offset[11:0];

   assign is_ctrl  = in_win && (ofs12 == CTRL_OFS);
   assign is_mode  = in_win && (ofs12 == MODE_OFS);
   // Upper bound DATA_OFS_HI is the window top, so only the low bound matters
   assign is_data  = in_win && (ofs12 >= DATA_OFS_LO);
   assign err      = !(is_ctrl || is_mode || is_data);

   // Index is the raw byte offset past the DATA base, not word-scaled
   assign idx_full = ofs12 - DATA_OFS_LO;
   assign buf_idx  = BUF_AW'(idx_full);

endmodule
`default_nettype wire

// File: rtl/icb_acc_frontend.sv
`default_nettype none
// ============================================================================
//  Module      : icb_acc_frontend
//  Description : ICB slave front-end for the convolution/tanh core. Decodes
//                CTRL/MODE registers and a DATA window mapped onto a
//                single-cycle buffer port; one outstanding transaction.
//  Ports       : clk/rst            - clock, async active-high reset
//                icb_cmd_*          - ICB command channel
//                icb_rsp_*          - ICB response channel
//                start_pulse/mode   - core control
//                done_i             - core completion
//                buf_*              - buffer port (read data 1 cycle after buf_re)
//  Revision    : 1.0  initial release
// ============================================================================
module icb_acc_frontend
   import acc_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h1004_2000,
   parameter int          BUF_AW    = 12,
   parameter int          DW        = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              icb_cmd_valid,
   output logic              icb_cmd_ready,
   input  logic              icb_cmd_read,
   input  logic [31:0]       icb_cmd_addr,
   input  logic [DW-1:0]     icb_cmd_wdata,
   input  logic [3:0]        icb_cmd_wmask,
   output logic              icb_rsp_valid,
   input  logic              icb_rsp_ready,
   output logic [DW-1:0]     icb_rsp_rdata,
   output logic              icb_rsp_err,
   output logic              start_pulse,
   output logic [1:0]        mode,
   input  logic              done_i,
   output logic              buf_we,
   output logic              buf_re,
   output logic [BUF_AW-1:0] buf_addr,
   output logic [DW-1:0]     buf_wdata,
   output logic [3:0]        buf_wmask,
   input  logic [DW-1:0]     buf_rdata
);

   state_e              state_q, state_d;
   logic                is_ctrl, is_mode, is_data, dec_err;
   logic [BUF_AW-1:0]   buf_idx;
   logic                busy_q, done_sticky_q;
   logic                rd_pass_q;
   logic [DW-1:0]       rdata_q, rdata_d;
   logic                err_d;
   logic                cmd_hs, is_wr, mask_any, start_req, start_go;

   icb_addr_decode #(
      .BASE_ADDR (BASE_ADDR),
      .BUF_AW    (BUF_AW)
   ) u_dec (
      .addr    (icb_cmd_addr),
      .is_ctrl (is_ctrl),
      .is_mode (is_mode),
      .is_data (is_data),
      .buf_idx (buf_idx),
      .err     (dec_err)
   );

   // Ready is forced low while reset is held, even though state is already IDLE
   assign icb_cmd_ready = (state_q == S_IDLE) && !rst;
   assign cmd_hs        = icb_cmd_valid && icb_cmd_ready;
   assign is_wr         = !icb_cmd_read;
   assign mask_any      = |icb_cmd_wmask;
   assign start_req     = cmd_hs && is_wr && is_ctrl && icb_cmd_wmask[0] && icb_cmd_wdata[0];
   assign start_go      = start_req && !busy_q;

   assign icb_rsp_valid = (state_q == S_RSP);
   // First RSP cycle after a buffer read forwards the buffer output directly;
   // it is captured at that edge so later cycles hold the same value.
   assign icb_rsp_rdata = rd_pass_q ? buf_rdata : rdata_q;

   always_comb begin
      err_d = dec_err;
      if (is_wr && is_ctrl && icb_cmd_wmask[0] && icb_cmd_wdata[0] && busy_q) err_d = 1'b1;
      if (is_wr && (is_mode || is_data) && busy_q)                           err_d = 1'b1;
   end

   always_comb begin
      rdata_d = '0;
      if (icb_cmd_read && is_ctrl) rdata_d[1:0] = {done_sticky_q, busy_q};
      if (icb_cmd_read && is_mode) rdata_d[1:0] = mode;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (cmd_hs) state_d = (icb_cmd_read && is_data) ? S_RD_WAIT : S_RSP;
         S_RD_WAIT: state_d = S_RSP;
         S_RSP:     if (icb_rsp_ready) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_pulse   <= 1'b0;
         mode          <= 2'd0;
         busy_q        <= 1'b0;
         done_sticky_q <= 1'b0;
         buf_we        <= 1'b0;
         buf_re        <= 1'b0;
         buf_addr      <= '0;
         buf_wdata     <= '0;
         buf_wmask     <= 4'd0;
         icb_rsp_err   <= 1'b0;
         rdata_q       <= '0;
         rd_pass_q     <= 1'b0;
      end else begin
         start_pulse <= start_go;
         buf_we      <= cmd_hs && is_wr && is_data && mask_any;
         buf_re      <= cmd_hs && icb_cmd_read && is_data;
         rd_pass_q   <= (state_q == S_RD_WAIT);

         // A start issued in the same cycle as done_i takes priority
         if (start_go) begin
            busy_q        <= 1'b1;
            done_sticky_q <= 1'b0;
         end else if (done_i) begin
            busy_q        <= 1'b0;
            done_sticky_q <= 1'b1;
         end

         if (cmd_hs && is_data && (icb_cmd_read || mask_any)) buf_addr <= buf_idx;
         if (cmd_hs && is_data && is_wr && mask_any) begin
            buf_wdata <= icb_cmd_wdata;
            buf_wmask <= icb_cmd_wmask;
         end

         if (cmd_hs && is_wr && is_mode && !busy_q && icb_cmd_wmask[0]) mode <= icb_cmd_wdata[1:0];

         if (cmd_hs) begin
            icb_rsp_err <= err_d;
            rdata_q     <= rdata_d;
         end else if (rd_pass_q) begin
            rdata_q     <= buf_rdata;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_icb_acc_frontend.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icb_acc_frontend
//  Description : Self-checking bench for icb_acc_frontend: directed scenarios
//                followed by randomized commands against a transaction-level
//                reference model of the register map and buffer contents.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_icb_acc_frontend;

   localparam logic [31:0] BASE = 32'h1004_2000;

   logic        clk = 1'b0;
   logic        rst;
   logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
   logic [31:0] icb_cmd_addr, icb_cmd_wdata;
   logic [3:0]  icb_cmd_wmask;
   logic        icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
   logic [31:0] icb_rsp_rdata;
   logic        start_pulse, done_i, buf_we, buf_re;
   logic [1:0]  mode;
   logic [11:0] buf_addr;
   logic [31:0] buf_wdata;
   logic [3:0]  buf_wmask;
   logic [31:0] buf_rdata = 32'd0;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   bit [31:0] ref_mem [4096];
   bit [31:0] env_mem [4096];
   bit        m_busy, m_done, auto_done;
   logic [1:0] m_mode;

   icb_acc_frontend dut (
      .clk(clk), .rst(rst),
      .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
      .icb_cmd_read(icb_cmd_read), .icb_cmd_addr(icb_cmd_addr),
      .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
      .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
      .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
      .start_pulse(start_pulse), .mode(mode), .done_i(done_i),
      .buf_we(buf_we), .buf_re(buf_re), .buf_addr(buf_addr),
      .buf_wdata(buf_wdata), .buf_wmask(buf_wmask), .buf_rdata(buf_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] wm);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (wm[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   // Buffer environment: read data valid the cycle after buf_re, garbage otherwise
   always @(posedge clk) begin
      if (buf_we) env_mem[buf_addr] <= merge(env_mem[buf_addr], buf_wdata, buf_wmask);
      if (buf_re) buf_rdata <= env_mem[buf_addr];
      else        buf_rdata <= $urandom;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; apply the core busy/done rule to the model at the edge
   task automatic step(input bit start_go);
      @(posedge clk);
      if (start_go) begin
         m_busy = 1'b1;
         m_done = 1'b0;
      end else if (done_i) begin
         m_busy = 1'b0;
         m_done = 1'b1;
      end
      @(negedge clk);
      done_i = auto_done && m_busy && ($urandom_range(0, 4) == 0);
   endtask

   // One full ICB transaction, issued from IDLE at a negedge
   task automatic do_cmd(input bit rd, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] wm, input int hold);
      logic [31:0] ofs, e_rdata;
      bit inwin, is_c, is_m, is_d, e_err, e_we, e_re, go;
      int idx;
      ofs   = addr - BASE;
      inwin = (ofs < 32'd4096);
      is_c  = inwin && (ofs == 32'd0);
      is_m  = inwin && (ofs == 32'd4);
      is_d  = inwin && (ofs >= 32'd8);
      idx   = is_d ? int'(ofs) - 8 : 0;
      e_err = 0; e_we = 0; e_re = 0; go = 0; e_rdata = 32'd0;
      if (!(is_c || is_m || is_d)) e_err = 1;
      else if (is_c) begin
         if (rd) e_rdata = {30'd0, m_done, m_busy};
         else if (wm[0] && wd[0]) begin
            if (m_busy) e_err = 1;
            else        go = 1;
         end
      end else if (is_m) begin
         if (rd) e_rdata = {30'd0, m_mode};
         else if (m_busy) e_err = 1;
         else if (wm[0]) m_mode = wd[1:0];
      end else begin
         if (rd) begin
            e_re    = 1;
            e_rdata = ref_mem[idx];
         end else begin
            e_err = m_busy;
            if (wm != 4'd0) begin
               e_we = 1;
               ref_mem[idx] = merge(ref_mem[idx], wd, wm);
            end
         end
      end

      icb_cmd_valid = 1'b1; icb_cmd_read = rd; icb_cmd_addr = addr;
      icb_cmd_wdata = wd;   icb_cmd_wmask = wm;
      check("cmd_ready_idle", 32'(icb_cmd_ready), 32'd1);
      step(go);
      icb_cmd_valid = 1'b0; icb_cmd_wdata = $urandom; icb_cmd_addr = $urandom;

      check("start_pulse", 32'(start_pulse), 32'(go));
      check("buf_we", 32'(buf_we), 32'(e_we));
      check("buf_re", 32'(buf_re), 32'(e_re));
      check("mode_out", 32'(mode), 32'(m_mode));
      if (e_we) begin
         check("buf_addr_wr", 32'(buf_addr), 32'(idx));
         check("buf_wdata", buf_wdata, wd);
         check("buf_wmask", 32'(buf_wmask), 32'(wm));
      end
      if (e_re) begin
         check("buf_addr_rd", 32'(buf_addr), 32'(idx));
         check("rd_wait_rsp_valid", 32'(icb_rsp_valid), 32'd0);
         step(0);
      end
      for (int i = 0; i <= hold; i++) begin
         if (i == hold) icb_rsp_ready = 1'b1;
         if (i > 0 || e_re) check("strobes_quiet", {29'd0, start_pulse, buf_we, buf_re}, 32'd0);
         check("rsp_valid", 32'(icb_rsp_valid), 32'd1);
         check("rsp_err", 32'(icb_rsp_err), 32'(e_err));
         check("rsp_rdata", icb_rsp_rdata, e_rdata);
         check("cmd_ready_busy", 32'(icb_cmd_ready), 32'd0);
         step(0);
      end
      icb_rsp_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] a, wd;
      logic [3:0]  wm;
      int          sel;

      rst = 1'b1; icb_cmd_valid = 0; icb_cmd_read = 0; icb_cmd_addr = 0;
      icb_cmd_wdata = 0; icb_cmd_wmask = 0; icb_rsp_ready = 0; done_i = 0;
      m_busy = 0; m_done = 0; m_mode = 2'd0; auto_done = 0;
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", 32'(icb_cmd_ready), 32'd0);
      check("rst_outs", {25'd0, icb_rsp_valid, icb_rsp_err, start_pulse, buf_we, buf_re, mode}, 32'd0);
      check("rst_buf", {buf_addr, 16'd0, buf_wmask}, 32'd0);
      check("rst_wdata", buf_wdata, 32'd0);
      check("rst_rdata", icb_rsp_rdata, 32'd0);
      rst = 1'b0;
      step(0);
      check("post_rst_ready", 32'(icb_cmd_ready), 32'd1);

      // Directed scenarios
      do_cmd(1, BASE, 0, 4'h0, 0);                       // CTRL reads 0 after reset
      do_cmd(0, BASE + 4, 32'd2, 4'hF, 0);
      check("mode_is_2", 32'(mode), 32'd2);
      do_cmd(1, BASE + 4, 0, 4'h0, 0);
      do_cmd(0, BASE + 8 + 5, 32'hABCD_1234, 4'hF, 0);
      do_cmd(0, BASE + 8 + 4087, 32'hDEAD_BEEF, 4'hF, 0);
      do_cmd(1, BASE + 8 + 4087, 0, 4'h0, 5);            // held response, buffer output scrambled
      do_cmd(0, BASE, 32'd1, 4'h1, 0);                   // start
      do_cmd(1, BASE, 0, 4'h0, 0);                       // busy = 1
      do_cmd(0, BASE, 32'd1, 4'hF, 0);                   // start while busy -> err
      do_cmd(0, BASE + 4, 32'd1, 4'hF, 0);               // MODE write while busy -> err
      done_i = 1'b1;
      step(0);
      do_cmd(1, BASE, 0, 4'h0, 0);                       // done_sticky = 1
      do_cmd(0, BASE + 32'h1000, 32'h5555_5555, 4'hF, 2); // outside window
      do_cmd(1, BASE + 2, 0, 4'h0, 0);                   // unmapped offset
      do_cmd(0, BASE + 8 + 5, 32'h1111_1111, 4'h0, 0);   // zero mask: no write
      do_cmd(1, BASE + 8 + 5, 0, 4'h0, 0);
      do_cmd(0, BASE + 8 + 6, 32'hCAFE_F00D, 4'h5, 1);   // partial mask
      do_cmd(1, BASE + 8 + 6, 0, 4'h0, 0);

      // Reset during RD_WAIT
      icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = BASE + 8 + 5;
      step(0);
      icb_cmd_valid = 1'b0;
      check("mid_rst_re_before", 32'(buf_re), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_outs", {25'd0, icb_cmd_ready, icb_rsp_valid, start_pulse, buf_we, buf_re, mode}, 32'd0);
      check("mid_rst_addr", 32'(buf_addr), 32'd0);
      m_mode = 2'd0; m_busy = 0; m_done = 0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("no_rsp_after_rst", 32'(icb_rsp_valid), 32'd0);
         step(0);
      end
      do_cmd(0, BASE + 4, 32'd1, 4'hF, 0);
      do_cmd(1, BASE, 0, 4'h0, 0);

      // Randomized phase
      auto_done = 1'b1;
      for (int n = 0; n < 250; n++) begin
         sel = $urandom_range(0, 9);
         wd  = $urandom;
         wm  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         case (sel)
            0, 1:    a = BASE;
            2:       a = BASE + 4;
            8: begin
               a = BASE + 32'($urandom_range(1, 6));
               if (a == BASE + 4) a = BASE + 7;
            end
            9:       a = ($urandom_range(0, 1) == 1) ? BASE + 32'h1000 + 32'($urandom_range(0, 255))
                                                     : BASE - 32'($urandom_range(1, 64));
            default: a = BASE + 8 + (($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15))
                                                                 : 32'($urandom_range(0, 4087)));
         endcase
         do_cmd(1'($urandom_range(0, 1)), a, wd, wm, $urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) step(0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/icb_acc_frontend.md
Name: icb_acc_frontend

Overview:
- ICB slave front-end that sits directly upstream of the convolution/tanh accelerator core.
- Decodes CPU ICB commands in a 4 KB window into control/mode registers and single-cycle buffer-port writes and reads.
- Generates the start pulse, tracks busy/done, and returns ICB responses with at most one outstanding transaction.

Parameters:
- BASE_ADDR, 32'h1004_2000, window base; offset = icb_cmd_addr - BASE_ADDR.
- BUF_AW, 12, buffer address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- icb_cmd_valid  in  1  command valid.
- icb_cmd_ready  out  1  command ready.
- icb_cmd_read  in  1  1 = read, 0 = write.
- icb_cmd_addr  in  32  command address.
- icb_cmd_wdata  in  DW  write data.
- icb_cmd_wmask  in  4  byte write mask.
- icb_rsp_valid  out  1  response valid.
- icb_rsp_ready  in  1  response ready.
- icb_rsp_rdata  out  DW  read data.
- icb_rsp_err  out  1  decode/protocol error.
- start_pulse  out  1  one-cycle core start.
- mode  out  2  load-target select (0 weights/run, 1 ifmap, 2 tanh LUT, 3 reserved).
- done_i  in  1  core done pulse/level.
- buf_we  out  1  buffer write strobe.
- buf_re  out  1  buffer read strobe.
- buf_addr  out  BUF_AW  buffer word index.
- buf_wdata  out  DW  buffer write data.
- buf_wmask  out  4  buffer byte mask.
- buf_rdata  in  DW  buffer read data, valid 1 cycle after buf_re.

Behaviour:
- Address map (offset in bytes):
  - 0x000 CTRL: W bit0 = start. R = {30'b0, done_sticky, busy}.
  - 0x004 MODE: R/W bits[1:0].
  - 0x008..0xFFF DATA: buf_addr = offset - 8, giving indices 0..4087. Index is the raw offset, not byte-scaled.
  - Any other offset, including addresses outside the window: err.
- FSM states IDLE, RD_WAIT, RSP.
  - icb_cmd_ready = (state == IDLE). Handshake at cycle T when valid and ready.
  - IDLE → RSP at T+1 for register access, DATA write, or error.
  - IDLE → RD_WAIT for a DATA read. buf_re pulses at T+1. At T+2, buf_rdata is captured into rsp_rdata and the FSM enters RSP.
  - RSP holds icb_rsp_valid and all rsp fields stable until icb_rsp_ready. On that handshake → IDLE.
  - Back-to-back throughput is therefore one command per 2 cycles for writes and 3 cycles for buffer reads.
- DATA write: buf_we pulses at T+1 with registered buf_addr, buf_wdata, and buf_wmask = icb_cmd_wmask. buf_we and buf_re are never both high.
- MODE write: bytes are updated per wmask[0] only. The new value is visible at T+1.
- CTRL write with wdata[0] = 1 and wmask[0] = 1:
  - If not busy: start_pulse = 1 at T+1 for exactly one cycle; busy set; done_sticky cleared.
  - If busy: no pulse and err = 1.
- done_i = 1 clears busy and sets done_sticky on the next edge. If done_i coincides with a start being issued, start wins: busy stays 1 and done_sticky stays 0.
- DATA writes while busy are performed but flagged err = 1 (debug aid). MODE writes while busy are ignored with err = 1.
- Reads of a write-only bit return 0. Error responses return rdata = 0 and have no side effects.
- Reset values: icb_cmd_ready = 0 during rst, then 1. rsp_valid, rsp_err, rsp_rdata, start_pulse, buf_we, buf_re, buf_addr, buf_wdata, buf_wmask = 0. mode = 0, busy = 0, done_sticky = 0.
- Reset asserted mid-transaction drops the pending response immediately; no response is emitted afterwards.
- icb_cmd_wmask = 0 on a write: handshake and respond with no state change and no buf_we.

Decomposition:
- Shared package acc_pkg holds:
  - offset constants CTRL_OFS, MODE_OFS, DATA_OFS_LO = 12'h008, DATA_OFS_HI = 12'hFFF;
  - the mode enum (MODE_RUN, MODE_IFMAP, MODE_LUT);
  - the FSM state typedef.
- One natural sub-module: icb_addr_decode, combinational, mapping addr → {is_ctrl, is_mode, is_data, buf_idx, err}.

Test Plan:
- Write MODE = 2 at 0x1004_2004 → rsp_valid 1 cycle after handshake, err = 0; read back returns 32'h2.
- Write 32'hABCD_1234 to 0x1004_2008 + 5 → buf_we for 1 cycle with buf_addr = 5, wdata = 32'hABCD_1234, wmask = 4'hF.
- Read 0x1004_2008 + 4087 with buf_rdata model = 32'hDEAD_BEEF → buf_re at T+1, buf_addr = 4087, rsp_rdata = 32'hDEAD_BEEF at T+2.
- Write CTRL = 1 → start_pulse 1 cycle, CTRL read = 1. Second start before done → err = 1, no pulse. Pulse done_i → CTRL read = 2.
- Hold icb_rsp_ready = 0 for 5 cycles → rsp fields stable and cmd_ready = 0 throughout. Access to 0x1004_3000 → err = 1 with no buf_we.
- Assert rst during RD_WAIT → all outputs 0 immediately; after release, mode = 0 and the next write completes normally.
